alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_class.sv | 40 ++++
 rtl/alu_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode map, sequencer state encoding and default
//               multi-cycle wait values for the ALU control path.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [4:0] c_OP_ADD  = 5'd3;
    localparam logic [4:0] c_OP_SUB  = 5'd4;
    localparam logic [4:0] c_OP_AND  = 5'd5;
    localparam logic [4:0] c_OP_OR   = 5'd6;
    localparam logic [4:0] c_OP_XOR  = 5'd7;
    localparam logic [4:0] c_OP_SLL  = 5'd8;
    localparam logic [4:0] c_OP_SRL  = 5'd9;
    localparam logic [4:0] c_OP_SRA  = 5'd10;
    localparam logic [4:0] c_OP_SLT  = 5'd11;
    localparam logic [4:0] c_OP_MUL  = 5'd15;
    localparam logic [4:0] c_OP_DIV  = 5'd16;
    localparam logic [4:0] c_OP_SLTU = 5'd17;
    localparam logic [4:0] c_OP_CMP  = 5'd18;

    localparam int DEFAULT_MUL_WAIT = 2;
    localparam int DEFAULT_DIV_WAIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_class.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_class
// Description : Combinational opcode classifier (legal / multiply / divide).
// Revision    : 1.0
// ============================================================================
module alu_op_class
    import alu_pkg::*;
(
    input  logic [4:0] i_op,
    output logic       o_legal,
    output logic       o_is_mul,
    output logic       o_is_div
);

    always_comb begin
        o_legal  = 1'b0;
        o_is_mul = 1'b0;
        o_is_div = 1'b0;
        case (i_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_SLL,
            c_OP_SRL, c_OP_SRA, c_OP_SLT, c_OP_SLTU, c_OP_CMP: begin
                o_legal = 1'b1;
            end
            c_OP_MUL: begin
                o_legal  = 1'b1;
                o_is_mul = 1'b1;
            end
            c_OP_DIV: begin
                o_legal  = 1'b1;
                o_is_div = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Request/response sequencer that holds operands on an external
//               ALU, waits the op-dependent latency and captures the result.
// Revision    : 1.0
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_WAIT = DEFAULT_MUL_WAIT,
    parameter int DIV_WAIT = DEFAULT_DIV_WAIT
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_op_select,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_result,
    output logic [31:0] z_lo,
    output logic [31:0] z_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err
);

    localparam int c_MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
    localparam int c_CNT_W    = (c_MAX_WAIT < 2) ? 1 : $clog2(c_MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_WAIT);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_WAIT);

    seq_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_z_lo;
    logic [31:0]        r_z_hi;
    logic               r_err;
    logic               r_req_ready;
    logic               r_rsp_valid;

    logic               w_legal;
    logic               w_is_mul;
    logic               w_is_div;

    alu_op_class u_op_class (
        .i_op     (req_op),
        .o_legal  (w_legal),
        .o_is_mul (w_is_mul),
        .o_is_div (w_is_div)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_z_lo      <= '0;
            r_z_hi      <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_req_ready <= 1'b0;
                        // Illegal ops and divide-by-zero skip the ALU wait entirely
                        if (!w_legal || (w_is_div && (req_b == '0))) begin
                            r_z_lo      <= '0;
                            r_z_hi      <= '0;
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cnt   <= w_is_mul ? c_MUL_LOAD :
                                       w_is_div ? c_DIV_LOAD : '0;
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_z_lo      <= alu_result[31:0];
                        r_z_hi      <= alu_result[63:32];
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_err;
    assign z_lo          = r_z_lo;
    assign z_hi          = r_z_hi;
    assign alu_op_select = r_op;
    assign alu_a         = r_a;
    assign alu_b         = r_b;

endmodule
`default_nettype wire
